// File: rtl/wb2axip_pktfifo_pkg.sv
// Shared helpers for the packet FIFO: pointer distance and memory word layout.
package wb2axip_pktfifo_pkg;

  // The last-of-packet flag sits directly above the data field.
  localparam int unsigned LAST_OFS = 0;

  function automatic int unsigned last_bit(input int unsigned bw);
    return bw + LAST_OFS;
  endfunction

  function automatic logic [31:0] ptr_dist(input logic [31:0] a, input logic [31:0] b);
    return a - b;
  endfunction

endpackage

// File: rtl/wb2axip_pktfifo_mem.sv
// Simple dual-port RAM backing the packet FIFO: synchronous write, asynchronous read.
module wb2axip_pktfifo_mem #(
  parameter int AW = 4,
  parameter int DW = 9
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [2**AW];

  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;

  assign rdata = mem[raddr];

endmodule

// File: rtl/wb2axip_pktfifo.sv
// Packet FIFO with commit/abort framing; words become readable only once their packet commits.
// Optional drop mode via WB2AXIP_PKTFIFO_DROP_ON_FULL_EN discards overflowing packets instead of back-pressuring.
module wb2axip_pktfifo
  import wb2axip_pktfifo_pkg::*;
#(
  parameter int BW     = 8,
  parameter int LGFLEN = 4
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_wr,
  input  logic [BW-1:0]   i_data,
  input  logic            i_last,
  input  logic            i_abort,
  input  logic [LGFLEN:0] i_afull_thresh,
  output logic            o_full,
  output logic            o_afull,
  output logic            o_drop,
  input  logic            i_rd,
  output logic [BW-1:0]   o_data,
  output logic            o_last,
  output logic            o_empty,
  output logic [LGFLEN:0] o_fill,
  output logic [LGFLEN:0] o_pkts
);

  localparam int PW = LGFLEN + 1;
  localparam int WW = BW + 1;
  localparam logic [PW-1:0] FLEN = {1'b1, {LGFLEN{1'b0}}};

  logic [PW-1:0] wr_addr, cm_addr, rd_addr, pkts;
  logic [PW-1:0] used;
  logic [WW-1:0] rd_word;
  logic          full_int, w_wr, w_rd, drop_now, commit, pop_last;

  assign used     = PW'(ptr_dist(32'(wr_addr), 32'(rd_addr)));
  assign full_int = (used == FLEN);
  assign o_empty  = (cm_addr == rd_addr);
  assign o_fill   = PW'(ptr_dist(32'(cm_addr), 32'(rd_addr)));
  assign o_afull  = (used >= i_afull_thresh);
  assign o_pkts   = pkts;

  assign w_rd     = i_rd && !o_empty;
  assign commit   = w_wr && i_last;
  assign pop_last = w_rd && rd_word[last_bit(BW)];

`ifdef WB2AXIP_PKTFIFO_DROP_ON_FULL_EN
  // Once a word overflows, the rest of that packet is swallowed until its last word rolls it back.
  logic ovf, drop_q;

  assign w_wr     = i_wr && !i_abort && !full_int && !ovf;
  assign drop_now = i_wr && !i_abort && i_last && (ovf || full_int);

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      ovf    <= 1'b0;
      drop_q <= 1'b0;
    end else begin
      drop_q <= drop_now;
      if (i_abort || drop_now)
        ovf <= 1'b0;
      else if (i_wr && full_int)
        ovf <= 1'b1;
    end
  end

  assign o_full = 1'b0;
  assign o_drop = drop_q;
`else
  assign w_wr     = i_wr && !i_abort && !full_int;
  assign drop_now = 1'b0;
  assign o_full   = full_int;
  assign o_drop   = 1'b0;
`endif

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      wr_addr <= '0;
      cm_addr <= '0;
      rd_addr <= '0;
      pkts    <= '0;
    end else begin
      if (i_abort || drop_now)
        wr_addr <= cm_addr;
      else if (w_wr)
        wr_addr <= wr_addr + PW'(1);
      if (commit)
        cm_addr <= wr_addr + PW'(1);
      if (w_rd)
        rd_addr <= rd_addr + PW'(1);
      case ({commit, pop_last})
        2'b10:   pkts <= pkts + PW'(1);
        2'b01:   pkts <= pkts - PW'(1);
        default: pkts <= pkts;
      endcase
    end
  end

  wb2axip_pktfifo_mem #(.AW(LGFLEN), .DW(WW)) u_mem (
    .clk   (i_clk),
    .we    (w_wr),
    .waddr (wr_addr[LGFLEN-1:0]),
    .wdata ({i_last, i_data}),
    .raddr (rd_addr[LGFLEN-1:0]),
    .rdata (rd_word)
  );

  assign o_data = rd_word[BW-1:0];
  assign o_last = rd_word[last_bit(BW)];

endmodule

// File: tb/tb_wb2axip_pktfifo.sv
// Self-checking bench for wb2axip_pktfifo: vector table plus scoreboard-backed corner sequences.
module tb_wb2axip_pktfifo;

  localparam int BW   = 8;
  localparam int LG   = 4;
  localparam int FLEN = 16;

  logic          i_clk = 1'b0;
  logic          i_reset = 1'b1;
  logic          i_wr = 1'b0, i_last = 1'b0, i_abort = 1'b0, i_rd = 1'b0;
  logic [BW-1:0] i_data = '0;
  logic [LG:0]   i_afull_thresh = '0;
  logic          o_full, o_afull, o_drop, o_last, o_empty;
  logic [BW-1:0] o_data;
  logic [LG:0]   o_fill, o_pkts;

  int checks = 0;
  int errors = 0;

  logic [BW:0] sb[$];
  logic [BW:0] pend[$];
  logic        movf = 1'b0;
  logic        mdrop = 1'b0;

  typedef struct {
    logic          wr;
    logic [BW-1:0] d;
    logic          last;
    logic          abort;
    logic          rd;
    int            fill;
    int            pkts;
    logic          empty;
  } vec_t;

  vec_t tbl[21];

  wb2axip_pktfifo #(.BW(BW), .LGFLEN(LG)) dut (
    .i_clk          (i_clk),
    .i_reset        (i_reset),
    .i_wr           (i_wr),
    .i_data         (i_data),
    .i_last         (i_last),
    .i_abort        (i_abort),
    .i_afull_thresh (i_afull_thresh),
    .o_full         (o_full),
    .o_afull        (o_afull),
    .o_drop         (o_drop),
    .i_rd           (i_rd),
    .o_data         (o_data),
    .o_last         (o_last),
    .o_empty        (o_empty),
    .o_fill         (o_fill),
    .o_pkts         (o_pkts)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int mpkts();
    int n = 0;
    foreach (sb[i]) if (sb[i][BW]) n++;
    return n;
  endfunction

  task automatic chk_flags(input string tag);
    int used;
    used = sb.size() + pend.size();
    chk({tag, ".empty"}, 32'(o_empty), 32'(sb.size() == 0));
    chk({tag, ".fill"},  32'(o_fill),  32'(sb.size()));
    chk({tag, ".pkts"},  32'(o_pkts),  32'(mpkts()));
`ifdef WB2AXIP_PKTFIFO_DROP_ON_FULL_EN
    chk({tag, ".full"},  32'(o_full),  32'(0));
`else
    chk({tag, ".full"},  32'(o_full),  32'(used == FLEN));
`endif
    chk({tag, ".afull"}, 32'(o_afull), 32'(used >= int'(i_afull_thresh)));
    chk({tag, ".drop"},  32'(o_drop),  32'(mdrop));
  endtask

  // One clock of stimulus; the model decides acceptance from pre-edge occupancy.
  task automatic cycle(input logic wr, input logic [BW-1:0] d, input logic last,
                       input logic abort, input logic rd);
    logic [BW:0] exp;
    bit          mfull;
    mfull   = (sb.size() + pend.size()) == FLEN;
    i_wr    = wr;
    i_data  = d;
    i_last  = last;
    i_abort = abort;
    i_rd    = rd;
    #1;
    if (rd && sb.size() > 0) begin
      exp = sb.pop_front();
      chk("pop", 32'({o_last, o_data}), 32'(exp));
    end
    mdrop = 1'b0;
    if (wr && !abort) begin
`ifdef WB2AXIP_PKTFIFO_DROP_ON_FULL_EN
      if (movf || mfull) begin
        if (last) begin
          pend.delete();
          movf  = 1'b0;
          mdrop = 1'b1;
        end else begin
          movf = 1'b1;
        end
      end else
`else
      if (!mfull)
`endif
      begin
        pend.push_back({last, d});
        if (last) begin
          sb = {sb, pend};
          pend.delete();
        end
      end
    end
    if (abort) begin
      pend.delete();
      movf = 1'b0;
    end
    @(posedge i_clk);
    #1;
    i_wr    = 1'b0;
    i_last  = 1'b0;
    i_abort = 1'b0;
    i_rd    = 1'b0;
  endtask

  initial begin
    int dcount;

    // wr, data, last, abort, rd | fill, pkts, empty after the cycle
    tbl[0]  = '{1'b1, 8'hA1, 1'b0, 1'b0, 1'b0, 0, 0, 1'b1};
    tbl[1]  = '{1'b1, 8'hA2, 1'b0, 1'b0, 1'b0, 0, 0, 1'b1};
    tbl[2]  = '{1'b1, 8'hA3, 1'b1, 1'b0, 1'b0, 3, 1, 1'b0};
    tbl[3]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 2, 1, 1'b0};
    tbl[4]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1, 1, 1'b0};
    tbl[5]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 0, 0, 1'b1};
    tbl[6]  = '{1'b1, 8'h11, 1'b0, 1'b0, 1'b0, 0, 0, 1'b1};
    tbl[7]  = '{1'b1, 8'h12, 1'b0, 1'b0, 1'b0, 0, 0, 1'b1};
    tbl[8]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 0, 0, 1'b1};
    tbl[9]  = '{1'b1, 8'h55, 1'b1, 1'b0, 1'b0, 1, 1, 1'b0};
    tbl[10] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 0, 0, 1'b1};
    tbl[11] = '{1'b1, 8'h66, 1'b0, 1'b0, 1'b0, 0, 0, 1'b1};
    tbl[12] = '{1'b1, 8'h77, 1'b1, 1'b1, 1'b0, 0, 0, 1'b1};
    tbl[13] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 0, 0, 1'b1};
    tbl[14] = '{1'b1, 8'h88, 1'b1, 1'b0, 1'b0, 1, 1, 1'b0};
    tbl[15] = '{1'b1, 8'h99, 1'b0, 1'b0, 1'b1, 0, 0, 1'b1};
    tbl[16] = '{1'b1, 8'h9A, 1'b1, 1'b0, 1'b0, 2, 1, 1'b0};
    tbl[17] = '{1'b1, 8'hB0, 1'b1, 1'b0, 1'b1, 2, 2, 1'b0};
    tbl[18] = '{1'b1, 8'hC0, 1'b1, 1'b0, 1'b1, 2, 2, 1'b0};
    tbl[19] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1, 1, 1'b0};
    tbl[20] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 0, 0, 1'b1};

    // Reset values with threshold 0 (almost-full must read high)
    #2;
    chk("rst.empty", 32'(o_empty), 32'(1));
    chk("rst.full",  32'(o_full),  32'(0));
    chk("rst.afull", 32'(o_afull), 32'(1));
    chk("rst.drop",  32'(o_drop),  32'(0));
    chk("rst.fill",  32'(o_fill),  32'(0));
    chk("rst.pkts",  32'(o_pkts),  32'(0));
    i_afull_thresh = 5'd12;
    #10;
    i_reset = 1'b0;
    @(posedge i_clk);
    #1;

    foreach (tbl[i]) begin
      cycle(tbl[i].wr, tbl[i].d, tbl[i].last, tbl[i].abort, tbl[i].rd);
      chk("tbl.fill",  32'(o_fill),  32'(tbl[i].fill));
      chk("tbl.pkts",  32'(o_pkts),  32'(tbl[i].pkts));
      chk("tbl.empty", 32'(o_empty), 32'(tbl[i].empty));
      chk_flags("tbl");
    end

    // Fill to capacity with one 16-word packet
    for (int k = 0; k < FLEN; k++) begin
      cycle(1'b1, 8'(8'h10 + k), k == FLEN - 1, 1'b0, 1'b0);
      chk_flags("fill16");
    end
`ifndef WB2AXIP_PKTFIFO_DROP_ON_FULL_EN
    chk("full16.full", 32'(o_full), 32'(1));
`endif
    chk("full16.pkts", 32'(o_pkts), 32'(1));
    chk("full16.fill", 32'(o_fill), 32'(16));
    cycle(1'b1, 8'hEE, 1'b1, 1'b0, 1'b0);
    chk_flags("refuse17");
    cycle(1'b1, 8'hEF, 1'b1, 1'b0, 1'b1);
    chk_flags("pop_same_cycle");
    cycle(1'b1, 8'hF0, 1'b1, 1'b0, 1'b0);
    chk_flags("after_pop_write");
    for (int k = 0; k < 20; k++) begin
      cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
      chk_flags("drain16");
    end

    // Almost-full counts uncommitted words
    for (int k = 0; k < 12; k++) begin
      cycle(1'b1, 8'(8'h30 + k), 1'b0, 1'b0, 1'b0);
      chk("afull_rise", 32'(o_afull), 32'(k >= 11));
      chk_flags("afull");
    end
    cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    chk("afull_abort", 32'(o_afull), 32'(0));
    chk_flags("afull_abort");

`ifdef WB2AXIP_PKTFIFO_DROP_ON_FULL_EN
    dcount = 0;
    for (int k = 0; k < 10; k++) begin
      cycle(1'b1, 8'(8'h40 + k), k == 9, 1'b0, 1'b0);
      dcount += int'(o_drop);
      chk_flags("drop_p1");
    end
    for (int k = 0; k < 10; k++) begin
      cycle(1'b1, 8'(8'h60 + k), k == 9, 1'b0, 1'b0);
      dcount += int'(o_drop);
      chk_flags("drop_p2");
    end
    cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    dcount += int'(o_drop);
    chk("drop.count", 32'(dcount), 32'(1));
    chk("drop.fill",  32'(o_fill), 32'(10));
    chk("drop.pkts",  32'(o_pkts), 32'(1));
    for (int k = 0; k < 11; k++) begin
      cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
      chk_flags("drop_drain");
    end
`else
    dcount = 0;
`endif

    // Async reset mid-packet with 5 committed and 3 pending words
    i_afull_thresh = 5'd4;
    for (int k = 0; k < 8; k++) begin
      cycle(1'b1, 8'(8'h70 + k), k == 4, 1'b0, 1'b0);
      chk_flags("pre_reset");
    end
    #3;
    i_reset = 1'b1;
    #1;
    chk("arst.empty", 32'(o_empty), 32'(1));
    chk("arst.full",  32'(o_full),  32'(0));
    chk("arst.afull", 32'(o_afull), 32'(0));
    chk("arst.drop",  32'(o_drop),  32'(0));
    chk("arst.fill",  32'(o_fill),  32'(0));
    chk("arst.pkts",  32'(o_pkts),  32'(0));
    i_afull_thresh = 5'd0;
    #1;
    chk("arst.afull0", 32'(o_afull), 32'(1));
    sb.delete();
    pend.delete();
    movf  = 1'b0;
    mdrop = 1'b0;
    i_afull_thresh = 5'd12;
    @(negedge i_clk);
    i_reset = 1'b0;
    @(posedge i_clk);
    #1;
    cycle(1'b1, 8'h5A, 1'b1, 1'b0, 1'b0);
    chk_flags("post_reset_wr");
    cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    chk_flags("post_reset_rd");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb2axip_pktfifo.md
# wb2axip_pktfifo

Synchronous packet FIFO. It is the parametrised successor to the team's plain synchronous data FIFO, adding packet framing, commit/abort of partially written packets, a packet counter and a programmable almost-full flag. Data written to the FIFO stays invisible to the reader until the packet's last word is accepted; an aborted packet is rolled back completely. It sits between bus-bridge front ends (AXI-stream/Wishbone capture logic) and consumers that must never see a truncated packet.

## Interface
Parameters:
- BW, 8, data width in bits
- LGFLEN, 4, log2 of FIFO depth; FLEN = 2**LGFLEN words

Ports:
- i_clk  in  1  clock
- i_reset  in  1  asynchronous, active-high reset
- i_wr  in  1  write request
- i_data  in  BW  write data
- i_last  in  1  marks the last word of a packet; commits the packet
- i_abort  in  1  discards all uncommitted words
- i_afull_thresh  in  LGFLEN+1  almost-full threshold, in words
- o_full  out  1  no space for another word (committed + uncommitted == FLEN)
- o_afull  out  1  (committed + uncommitted) >= i_afull_thresh
- o_drop  out  1  one-cycle pulse: a packet was discarded by overflow (see Configuration)
- i_rd  in  1  read/pop request
- o_data  out  BW  head-of-FIFO data, combinational from memory
- o_last  out  1  head word is the last word of its packet
- o_empty  out  1  no committed word available
- o_fill  out  LGFLEN+1  committed words held
- o_pkts  out  LGFLEN+1  complete packets held

## Operation
- Three LGFLEN+1-bit pointers: wr_addr (speculative write), cm_addr (commit), rd_addr. All arithmetic is modulo 2**(LGFLEN+1). Memory index uses the low LGFLEN bits. Each memory word is BW+1 bits: {last, data}.
- w_wr = i_wr && !o_full && !i_abort. It writes {i_last, i_data} at wr_addr and increments wr_addr. If i_last is also set, cm_addr <= wr_addr+1 and o_pkts increments.
- i_abort: wr_addr <= cm_addr. Any word presented in the same cycle is discarded, even with i_last set. Abort takes priority over everything on the write side.
- w_rd = i_rd && !o_empty. It increments rd_addr. If the popped word has last set, o_pkts decrements. A commit and a last-pop in the same cycle leave o_pkts unchanged.
- Flag definitions:
  - o_full = (wr_addr - rd_addr) == FLEN.
  - o_empty = (cm_addr == rd_addr).
  - o_fill = cm_addr - rd_addr.
  - o_afull follows the definition above.
  - All four are registered or derived only from registered pointers. They do not depend combinationally on i_rd or i_wr.
- Reads never touch uncommitted words, so a reader can drain committed packets while a new packet is being written.
- A packet longer than FLEN leaves o_full high with o_pkts == 0. Without drop mode, upstream must assert i_abort.
- Reset (async): all pointers and counters 0. Outputs after reset: o_empty=1, o_full=0, o_afull = (i_afull_thresh == 0), o_drop=0, o_fill=0, o_pkts=0. o_data/o_last are undefined while empty. Reset mid-packet discards everything.

## Timing
- Commit latency: the word with i_last accepted in cycle N is visible in cycle N+1 (o_empty falls, o_fill and o_pkts updated).
- Read: o_data/o_last are valid combinationally while !o_empty. A pop in cycle N exposes the next word in cycle N+1.
- Full: when full, a pop in cycle N frees space for a write in cycle N+1, never in the same cycle.
- Pointer wrap: behaviour is identical across the 2**(LGFLEN+1) pointer roll-over. Full and empty are distinguished by the MSB.

## Configuration
- WB2AXIP_PKTFIFO_DROP_ON_FULL_EN defined (drop mode):
  - o_full is forced low toward the writer.
  - A write attempted while physically full sets an internal overflow flag. While the flag is set, writes are ignored.
  - When the packet's last word is presented, wr_addr <= cm_addr, the flag clears and o_drop pulses for one cycle. Nothing is committed.
  - i_abort also clears the flag, without an o_drop pulse.
- Macro undefined: o_full provides back-pressure and o_drop is tied to 0.

## Structure
- Package wb2axip_pktfifo_pkg: the pointer-distance function (modulo subtract) and the memory word layout constant (last bit at index BW).
- One sub-module, wb2axip_pktfifo_mem: simple dual-port RAM, FLEN x (BW+1), synchronous write, asynchronous read.

## Test plan
- LGFLEN=4: write 3 words 0xA1,0xA2,0xA3 (last on 0xA3) -> o_empty stays 1 through the 0xA3 cycle, then o_fill=3, o_pkts=1; reads return A1,A2,A3 with o_last only on A3.
- Write 2 words, then i_abort; then a 1-word packet 0x55 -> o_fill=1, reads return only 0x55.
- Write 16 words with last on word 16 -> o_full=1, o_pkts=1. The 17th write is refused; a pop then allows the write in the next cycle.
- i_afull_thresh=12: o_afull rises on the cycle after the 12th word is accepted, counting uncommitted words.
- Drop mode: 10-word packet committed, then a 10-word packet -> o_drop pulses once at its last word, o_fill=10, o_pkts=1, first packet reads intact.
- Assert i_reset asynchronously mid-packet with 5 committed words -> all outputs return to reset values without a clock edge.
